snake_dir_ctrl: RTL and testbench

Turns raw direction and speed push-buttons into a committed snake heading and a one-cycle step strobe. It sits directly upstream of the snake body controller and paces it from the LCD frame strobe produced by the image generator. Button presses are synchronized, edge-detected and filtered for reversals. Accepted turns are buffered in a 2-entry queue, so fast double-turns between steps are not lost.

---
 rtl/snake_pkg.sv | 19 +
 rtl/pb_edge.sv | 28 ++
 rtl/snake_dir_ctrl.sv | 120 ++++++++++++
 tb/tb_snake_dir_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game blocks.
// Heading encoding is chosen so a reversal only flips bit 0.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/pb_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A held button yields a single one-cycle press pulse.
module pb_edge (
  input  logic clk,
  input  logic nrst,
  input  logic pb,
  output logic press
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= pb;
      s2    <= s1;
      s3    <= s2;
      press <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Converts direction/speed buttons into a committed heading and a step strobe
// paced by the LCD frame strobe; accepted turns wait in a 2-entry queue.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned SLOW_FRAMES = 8,
  parameter int unsigned FAST_FRAMES = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] direction_pb,
  input  logic       pb_mode,
  input  logic       sync,
  input  logic       halt,
  output logic [1:0] dir,
  output logic       move,
  output logic       fast
);

  localparam logic [7:0] SLOW_P = SLOW_FRAMES[7:0];
  localparam logic [7:0] FAST_P = FAST_FRAMES[7:0];

  logic [3:0] dir_press;
  logic       mode_press;

  for (genvar i = 0; i < 4; i++) begin : g_dir_pb
    pb_edge u_edge (.clk(clk), .nrst(nrst), .pb(direction_pb[i]), .press(dir_press[i]));
  end

  pb_edge u_mode_edge (.clk(clk), .nrst(nrst), .pb(pb_mode), .press(mode_press));

  dir_t       dir_q;
  dir_t       q0;
  dir_t       q1;
  logic [1:0] count;
  logic [7:0] frame_cnt;
  logic       move_q;
  logic       fast_q;

  dir_t       req;
  logic       req_valid;
  dir_t       tail;
  logic [7:0] last;
  logic       step;
  logic       pop;
  logic       accept;

  // Tail is the newest queued heading, so a pop in the same cycle never alters the filter.
  always_comb begin
    req = DIR_RIGHT;
    if (dir_press[3])      req = DIR_UP;
    else if (dir_press[2]) req = DIR_DOWN;
    else if (dir_press[1]) req = DIR_LEFT;
    req_valid = |dir_press;

    if (count == 2'd2)      tail = q1;
    else if (count == 2'd1) tail = q0;
    else                    tail = dir_q;

    last   = (fast_q ? FAST_P : SLOW_P) - 8'd1;
    step   = sync & ~halt & ~mode_press & (frame_cnt == last);
    pop    = step & (count != 2'd0);
    accept = req_valid & ~halt & (req != tail) & (req != opposite(tail))
           & ((count != 2'd2) | pop);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q0    <= DIR_RIGHT;
      q1    <= DIR_RIGHT;
      count <= 2'd0;
    end else if (halt) begin
      count <= 2'd0;
    end else begin
      case ({pop, accept})
        2'b11: begin
          if (count == 2'd2) begin
            q0 <= q1;
            q1 <= req;
          end else begin
            q0 <= req;
          end
        end
        2'b10: begin
          q0    <= q1;
          count <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) q0 <= req;
          else               q1 <= req;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // A speed toggle beats a completing frame, so no step fires in that cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dir_q     <= DIR_RIGHT;
      move_q    <= 1'b0;
      fast_q    <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      move_q <= step;
      if (pop) dir_q <= q0;
      if (!halt && mode_press) fast_q <= ~fast_q;
      if (halt || mode_press)
        frame_cnt <= 8'd0;
      else if (sync)
        frame_cnt <= (frame_cnt == last) ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  assign dir  = dir_q;
  assign move = move_q;
  assign fast = fast_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl; expected steps go into a scoreboard
// queue and a monitor checks every move pulse against it.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [3:0] direction_pb = 4'b0000;
  logic       pb_mode = 1'b0;
  logic       sync = 1'b0;
  logic       halt = 1'b0;
  logic [1:0] dir;
  logic       move;
  logic       fast;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  snake_dir_ctrl #(.SLOW_FRAMES(8), .FAST_FRAMES(4)) dut (
    .clk(clk),
    .nrst(nrst),
    .direction_pb(direction_pb),
    .pb_mode(pb_mode),
    .sync(sync),
    .halt(halt),
    .dir(dir),
    .move(move),
    .fast(fast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [1:0] actual, input logic [1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  // Monitor: every move pulse must match the scoreboard head in cycle and heading.
  always @(negedge clk) begin
    if (nrst) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        checks++;
        if (move !== 1'b1) begin
          errors++;
          $display("[TB] FAIL move_missing: move=%0b expected 1 at cycle %0d", move, cyc);
        end else if (dir !== sb[0].dir) begin
          errors++;
          $display("[TB] FAIL step_dir: dir=%0b expected %0b at cycle %0d", dir, sb[0].dir, cyc);
        end
        void'(sb.pop_front());
      end else if (move !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL move_unexpected: move=%0b expected 0 at cycle %0d", move, cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sync(input bit exp_move, input logic [1:0] exp_dir);
    exp_t e;
    @(posedge clk);
    #1;
    sync = 1'b1;
    if (exp_move) begin
      e.dir = exp_dir;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    sync = 1'b0;
  endtask

  // n syncs; a move is expected on every multiple of period, counted from the first one.
  task automatic run_syncs(input int n, input int period, input logic [1:0] exp_dir);
    for (int i = 1; i <= n; i++) send_sync((period != 0) && (i % period == 0), exp_dir);
  endtask

  task automatic press_dir(input logic [3:0] bits);
    @(posedge clk);
    #1;
    direction_pb = bits;
    idle(6);
    direction_pb = 4'b0000;
    idle(4);
  endtask

  task automatic press_mode();
    @(posedge clk);
    #1;
    pb_mode = 1'b1;
    idle(6);
    pb_mode = 1'b0;
    idle(4);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(3);
    check_output("reset_dir", dir, 2'b00);
    check_output("reset_move", {1'b0, move}, 2'b00);
    check_output("reset_fast", {1'b0, fast}, 2'b00);
    nrst = 1'b1;
    idle(2);

    // Idle stepping: moves on the 8th and 16th sync with heading RIGHT.
    run_syncs(16, 8, 2'b00);

    // Reversal rejected, then a legal turn to UP.
    press_dir(4'b0010);
    run_syncs(8, 8, 2'b00);
    press_dir(4'b1000);
    run_syncs(8, 8, 2'b11);
    press_dir(4'b0001);
    run_syncs(8, 8, 2'b00);

    // Queued double turn from RIGHT: UP then LEFT.
    press_dir(4'b1000);
    press_dir(4'b0010);
    run_syncs(8, 8, 2'b11);
    run_syncs(8, 8, 2'b01);

    // Full queue from LEFT: UP, LEFT queued, DOWN dropped.
    press_dir(4'b1000);
    press_dir(4'b0010);
    press_dir(4'b0100);
    run_syncs(8, 8, 2'b11);
    run_syncs(8, 8, 2'b01);
    run_syncs(8, 8, 2'b01);

    // Speed toggle clears a partially counted period.
    run_syncs(3, 0, 2'b01);
    press_mode();
    check_output("fast_on", {1'b0, fast}, 2'b01);
    run_syncs(8, 4, 2'b01);
    run_syncs(2, 0, 2'b01);
    press_mode();
    check_output("fast_off", {1'b0, fast}, 2'b00);
    run_syncs(8, 8, 2'b01);

    // Halt with two entries queued flushes the queue and freezes stepping.
    press_dir(4'b1000);
    press_dir(4'b0001);
    run_syncs(5, 0, 2'b01);
    @(posedge clk);
    #1;
    halt = 1'b1;
    run_syncs(20, 0, 2'b01);
    check_output("halt_dir", dir, 2'b01);
    @(posedge clk);
    #1;
    halt = 1'b0;
    run_syncs(8, 8, 2'b01);

    // Simultaneous presses: UP wins over DOWN and LEFT.
    press_dir(4'b1110);
    run_syncs(8, 8, 2'b11);

    // Asynchronous reset restores heading and speed.
    press_mode();
    check_output("fast_before_reset", {1'b0, fast}, 2'b01);
    #3;
    nrst = 1'b0;
    #2;
    check_output("async_reset_dir", dir, 2'b00);
    check_output("async_reset_fast", {1'b0, fast}, 2'b00);
    check_output("async_reset_move", {1'b0, move}, 2'b00);
    idle(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d steps pending, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
